// File: rtl/graph_edge_server.sv
// graph_edge_server: responder for node-fetch requests from the path-accumulation
// engine. It holds a compressed adjacency graph (node table {count, base} plus an
// edge array) and streams a node's successors one per cycle, each tagged with the
// number of edges still to come (including the current one).
//
// Handshake: a fetch is started by rd_next_node=1 whenever it rises or node_idx
// changes while it is high. The stream is then pushed out with next_node_valid
// high for exactly count cycles; there is no back-pressure. A new request at
// any time aborts the running stream.
module graph_edge_server #(
    parameter int PARAM_NODE_IDX_WIDTH = 10,
    parameter int PARAM_COUNTER_WIDTH  = 4,
    parameter int PARAM_EDGE_DEPTH     = 2048,
    localparam int EA = $clog2(PARAM_EDGE_DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cfg_wr_en,
    input  logic                            cfg_tbl_sel,
    input  logic [EA-1:0]                   cfg_addr,
    input  logic [EA+PARAM_COUNTER_WIDTH-1:0] cfg_wdata,
    output logic                            cfg_err,
    input  logic [PARAM_NODE_IDX_WIDTH-1:0] node_idx,
    input  logic                            rd_next_node,
    output logic [PARAM_NODE_IDX_WIDTH-1:0] next_node_idx,
    output logic [PARAM_COUNTER_WIDTH-1:0]  next_node_counter,
    output logic                            next_node_valid,
    output logic                            no_edge,
    output logic                            busy
);
    localparam int NI    = PARAM_NODE_IDX_WIDTH;
    localparam int CW    = PARAM_COUNTER_WIDTH;
    localparam int NODES = 2 ** NI;

    typedef enum logic [1:0] {IDLE, TBL_RD, EDGE_RD, STREAM} state_t;

    state_t              state, state_n;
    logic [EA+CW-1:0]    node_tbl [NODES];
    logic [NI-1:0]       edge_mem [PARAM_EDGE_DEPTH];
    logic [NODES-1:0]    tbl_valid;
    logic [EA+CW-1:0]    tbl_q;
    logic                tv_q;
    logic [NI-1:0]       edge_q;
    logic                rd_q;
    logic [NI-1:0]       idx_q;
    logic [EA-1:0]       rd_addr, rd_addr_n, edge_raddr;
    logic [CW-1:0]       rem_q, rem_n;
    logic [CW-1:0]       cnt_n;
    logic [NI-1:0]       idx_n;
    logic                valid_n, no_edge_n;
    logic                new_req, wr_ok;
    logic [CW-1:0]       tbl_cnt;
    logic [EA-1:0]       tbl_base;

    // Edge addresses wrap modulo the edge array depth.
    function automatic logic [EA-1:0] addr_inc(input logic [EA-1:0] a);
        if (a == EA'(PARAM_EDGE_DEPTH - 1)) return '0;
        return a + EA'(1);
    endfunction

    assign busy     = (state != IDLE);
    assign wr_ok    = cfg_wr_en && !busy;
    assign new_req  = rd_next_node && (!rd_q || (node_idx != idx_q));
    // An unloaded node reads as having no edges.
    assign tbl_cnt  = tv_q ? tbl_q[EA+CW-1:EA] : '0;
    assign tbl_base = tbl_q[EA-1:0];

    // Memory array writes and synchronous reads (contents are not reset).
    always_ff @(posedge clk) begin
        if (wr_ok && cfg_tbl_sel)  node_tbl[cfg_addr[NI-1:0]] <= cfg_wdata;
        if (wr_ok && !cfg_tbl_sel) edge_mem[cfg_addr] <= cfg_wdata[NI-1:0];
        if (new_req) tbl_q <= node_tbl[node_idx];
        edge_q <= edge_mem[edge_raddr];
    end

    // Next-state and next-output logic; a new request overrides every state.
    always_comb begin
        state_n    = state;
        valid_n    = next_node_valid;
        idx_n      = next_node_idx;
        cnt_n      = next_node_counter;
        rd_addr_n  = rd_addr;
        rem_n      = rem_q;
        no_edge_n  = 1'b0;
        edge_raddr = rd_addr;
        if (new_req) begin
            state_n = TBL_RD;
            valid_n = 1'b0;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: ;
                TBL_RD: begin
                    if (tbl_cnt == '0) begin
                        no_edge_n = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        edge_raddr = tbl_base;
                        rd_addr_n  = addr_inc(tbl_base);
                        rem_n      = tbl_cnt;
                        state_n    = EDGE_RD;
                    end
                end
                EDGE_RD: begin
                    idx_n      = edge_q;
                    cnt_n      = rem_q;
                    valid_n    = 1'b1;
                    edge_raddr = rd_addr;
                    rd_addr_n  = addr_inc(rd_addr);
                    state_n    = STREAM;
                end
                STREAM: begin
                    if (next_node_counter > CW'(1)) begin
                        idx_n      = edge_q;
                        cnt_n      = next_node_counter - CW'(1);
                        edge_raddr = rd_addr;
                        rd_addr_n  = addr_inc(rd_addr);
                    end else begin
                        valid_n = 1'b0;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State, output and request-history registers with async active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            next_node_valid   <= 1'b0;
            next_node_idx     <= '0;
            next_node_counter <= '0;
            no_edge           <= 1'b0;
            cfg_err           <= 1'b0;
            rd_addr           <= '0;
            rem_q             <= '0;
            rd_q              <= 1'b0;
            idx_q             <= '0;
            tv_q              <= 1'b0;
            tbl_valid         <= '0;
        end else begin
            state             <= state_n;
            next_node_valid   <= valid_n;
            next_node_idx     <= idx_n;
            next_node_counter <= cnt_n;
            no_edge           <= no_edge_n;
            cfg_err           <= cfg_wr_en && busy;
            rd_addr           <= rd_addr_n;
            rem_q             <= rem_n;
            rd_q              <= rd_next_node;
            idx_q             <= node_idx;
            if (new_req) tv_q <= tbl_valid[node_idx];
            if (wr_ok && cfg_tbl_sel) tbl_valid[cfg_addr[NI-1:0]] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_graph_edge_server.sv
// Directed bench for graph_edge_server. Inputs change and outputs are sampled
// on the falling edge; "cycle +k" is k rising edges after the request sample.
module tb_graph_edge_server;
    localparam int NI = 10;
    localparam int CW = 4;
    localparam int EA = 11;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_wr_en, cfg_tbl_sel;
    logic [EA-1:0]     cfg_addr;
    logic [EA+CW-1:0]  cfg_wdata;
    logic              cfg_err;
    logic [NI-1:0]     node_idx;
    logic              rd_next_node;
    logic [NI-1:0]     next_node_idx;
    logic [CW-1:0]     next_node_counter;
    logic              next_node_valid, no_edge, busy;

    int checks = 0;
    int errors = 0;

    graph_edge_server dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_wr_en(cfg_wr_en), .cfg_tbl_sel(cfg_tbl_sel),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_err(cfg_err),
        .node_idx(node_idx), .rd_next_node(rd_next_node),
        .next_node_idx(next_node_idx), .next_node_counter(next_node_counter),
        .next_node_valid(next_node_valid), .no_edge(no_edge), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int idx, input int cnt, input int vld);
        chk({tag, "_idx"}, 32'(next_node_idx), 32'(idx));
        chk({tag, "_cnt"}, 32'(next_node_counter), 32'(cnt));
        chk({tag, "_vld"}, 32'(next_node_valid), 32'(vld));
    endtask

    task automatic cfg_write(input logic tbl, input int addr, input int data);
        cfg_wr_en   = 1'b1;
        cfg_tbl_sel = tbl;
        cfg_addr    = EA'(addr);
        cfg_wdata   = (EA+CW)'(data);
        tick();
        cfg_wr_en   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cfg_wr_en = 1'b0; cfg_tbl_sel = 1'b0; cfg_addr = '0;
        cfg_wdata = '0; node_idx = '0; rd_next_node = 1'b0;
        tick(); tick();
        chk("rst_valid", 32'(next_node_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_noedge", 32'(no_edge), 0);
        chk("rst_cfgerr", 32'(cfg_err), 0);
        rst_n = 1'b1;
        tick();

        // Load graph: node 5 {3,10}, node 3 {2,2047}, node 7 {15,100}.
        cfg_write(1'b1, 5, (3 << EA) | 10);
        chk("cfg_idle_err", 32'(cfg_err), 0);
        cfg_write(1'b0, 10, 7);
        cfg_write(1'b0, 11, 8);
        cfg_write(1'b0, 12, 9);
        cfg_write(1'b1, 3, (2 << EA) | 2047);
        cfg_write(1'b0, 2047, 1);
        cfg_write(1'b0, 0, 4);
        cfg_write(1'b1, 7, (15 << EA) | 100);
        for (int i = 0; i < 15; i++) cfg_write(1'b0, 100 + i, 200 + i);
        tick();

        // Basic 3-edge stream, rd_next_node held high afterwards.
        node_idx = 10'd5; rd_next_node = 1'b1;
        tick();
        chk("n5_busy0", 32'(busy), 1);
        chk("n5_vld0", 32'(next_node_valid), 0);
        tick();
        chk("n5_vld1", 32'(next_node_valid), 0);
        tick(); chk_out("n5_c2", 7, 3, 1);
        tick(); chk_out("n5_c3", 8, 2, 1);
        tick(); chk_out("n5_c4", 9, 1, 1);
        tick(); chk_out("n5_c5", 9, 0, 0);
        chk("n5_c5_busy", 32'(busy), 0);
        tick(); tick();
        chk("hold_busy", 32'(busy), 0);
        chk("hold_vld", 32'(next_node_valid), 0);
        rd_next_node = 1'b0;
        tick();

        // Unloaded node: no_edge pulse, never valid.
        node_idx = 10'd20; rd_next_node = 1'b1;
        tick();
        chk("n20_noedge0", 32'(no_edge), 0);
        tick();
        chk("n20_noedge1", 32'(no_edge), 1);
        chk("n20_vld1", 32'(next_node_valid), 0);
        tick();
        chk("n20_noedge2", 32'(no_edge), 0);
        chk("n20_busy2", 32'(busy), 0);
        chk("n20_vld2", 32'(next_node_valid), 0);
        rd_next_node = 1'b0;
        tick();

        // Edge address wrap 2047 -> 0.
        node_idx = 10'd3; rd_next_node = 1'b1;
        tick(); tick(); tick();
        chk_out("n3_c2", 1, 2, 1);
        tick(); chk_out("n3_c3", 4, 1, 1);
        tick(); chk("n3_c4_vld", 32'(next_node_valid), 0);
        rd_next_node = 1'b0;
        tick();

        // Abort node 5 after its first output by switching to node 3.
        node_idx = 10'd5; rd_next_node = 1'b1;
        tick(); tick(); tick();
        chk_out("ab_first", 7, 3, 1);
        node_idx = 10'd3;
        tick();
        chk_out("ab_drop", 7, 0, 0);
        chk("ab_busy", 32'(busy), 1);
        tick(); chk("ab_gap_vld", 32'(next_node_valid), 0);
        tick(); chk_out("ab_n3a", 1, 2, 1);
        tick(); chk_out("ab_n3b", 4, 1, 1);
        tick(); chk("ab_end_vld", 32'(next_node_valid), 0);
        rd_next_node = 1'b0;
        tick();

        // Config write while busy is dropped and flagged.
        node_idx = 10'd5; rd_next_node = 1'b1;
        tick();
        cfg_wr_en = 1'b1; cfg_tbl_sel = 1'b0; cfg_addr = EA'(10); cfg_wdata = (EA+CW)'(99);
        tick();
        cfg_wr_en = 1'b0;
        chk("busy_cfgerr", 32'(cfg_err), 1);
        tick();
        chk("busy_cfgerr_clr", 32'(cfg_err), 0);
        chk_out("busy_s1", 7, 3, 1);
        tick(); tick(); tick();
        chk("busy_end_vld", 32'(next_node_valid), 0);
        rd_next_node = 1'b0;
        tick();

        // Re-raise: full stream again, old edge data intact.
        rd_next_node = 1'b1;
        tick(); tick(); tick();
        chk_out("re_s1", 7, 3, 1);
        tick(); chk_out("re_s2", 8, 2, 1);
        tick(); chk_out("re_s3", 9, 1, 1);
        tick();
        rd_next_node = 1'b0;
        tick();

        // Maximum count of 15.
        node_idx = 10'd7; rd_next_node = 1'b1;
        tick(); tick();
        for (int k = 0; k < 15; k++) begin
            tick();
            chk_out($sformatf("max_%0d", k), 200 + k, 15 - k, 1);
        end
        tick();
        chk_out("max_end", 214, 0, 0);
        chk("max_end_busy", 32'(busy), 0);
        rd_next_node = 1'b0;
        tick();

        // Asynchronous reset mid-stream.
        node_idx = 10'd5; rd_next_node = 1'b1;
        tick(); tick(); tick(); tick();
        chk_out("prerst", 8, 2, 1);
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 0, 0, 0);
        chk("async_rst_busy", 32'(busy), 0);
        tick();
        rst_n = 1'b1; rd_next_node = 1'b0;
        tick();

        // tbl_valid cleared by reset: node 5 now reads as empty.
        rd_next_node = 1'b1;
        tick(); tick();
        chk("postrst_noedge", 32'(no_edge), 1);
        chk("postrst_vld", 32'(next_node_valid), 0);
        rd_next_node = 1'b0;
        tick();

        // Reload only the table entry; edge contents persisted through reset.
        cfg_write(1'b1, 5, (3 << EA) | 10);
        rd_next_node = 1'b1;
        tick(); tick(); tick();
        chk_out("persist_s1", 7, 3, 1);
        rd_next_node = 1'b0;
        tick(); tick(); tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
